// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared definitions for the fetch stage and the instruction prefetch queue:
// bus widths, stall bus layout, reset polarity and the default queue depth.
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

   localparam int STALL_BUS     = 6;   // stall controller bus width
   localparam int INST_ADDR_BUS = 32;  // instruction address width
   localparam int INST_BUS      = 32;  // instruction word width
   localparam int FETCH_Q_DEPTH = 4;   // default prefetch queue depth

   // This block uses an active-low reset.
   localparam logic RST_ENABLE = 1'b0;

   localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

   // Bit positions inside ctrl_stall.
   localparam int STALL_PC = 0;  // PC / fetch stage hold
   localparam int STALL_ID = 1;  // decode stage hold

endpackage : inst_fetch_queue_pkg

// File: rtl/inst_fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// fetch_q_mem
// DEPTH x {pc, inst} register array backing the prefetch queue.
// Synchronous write, asynchronous (combinational) read. Storage is not reset;
// the queue's occupancy count decides whether an entry is meaningful.
//
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write slot
//   wpc    - pc to store
//   winst  - instruction to store
//   raddr  - read slot
//   rpc    - pc stored at raddr
//   rinst  - instruction stored at raddr
// -----------------------------------------------------------------------------
module fetch_q_mem
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int PTR_W  = $clog2(DEPTH)
)
(
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [ADDR_W-1:0] wpc,
   input  logic [DATA_W-1:0] winst,
   input  logic [PTR_W-1:0]  raddr,
   output logic [ADDR_W-1:0] rpc,
   output logic [DATA_W-1:0] rinst
);

   logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= {wpc, winst};
      end
   end

   assign {rpc, rinst} = mem_q[raddr];

endmodule : fetch_q_mem

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Instruction prefetch queue between the PC stage / instruction ROM and the
// decode stage. Each fetched {pc, inst} pair is captured into a small circular
// FIFO; the head entry is presented to ID. A stall request is raised one entry
// before full so the stall controller has a cycle of slack, and a branch
// redirect discards the whole queue.
//
// Ports:
//   clk         - system clock, all state updates on the rising edge
//   rst         - asynchronous active-low reset
//   pc_i        - address driven by the PC stage
//   ce_i        - PC chip enable, fetch valid when high
//   inst_i      - ROM data for pc_i (same cycle)
//   ctrl_stall  - stall bus, [0] PC/fetch hold, [1] ID hold
//   flush       - branch redirect, empties the queue
//   id_pc       - pc of head entry (0 when empty)
//   id_inst     - instruction of head entry (0 = NOP bubble when empty)
//   id_valid    - head entry present
//   stallreq_if - fetch stall request (queue nearly full)
//   count_o     - occupancy
// -----------------------------------------------------------------------------
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH  = FETCH_Q_DEPTH,
   parameter int ADDR_W = INST_ADDR_BUS,
   parameter int DATA_W = INST_BUS
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        pc_i,
   input  logic                     ce_i,
   input  logic [DATA_W-1:0]        inst_i,
   input  logic [STALL_BUS-1:0]     ctrl_stall,
   input  logic                     flush,
   output logic [ADDR_W-1:0]        id_pc,
   output logic [DATA_W-1:0]        id_inst,
   output logic                     id_valid,
   output logic                     stallreq_if,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              enq;
   logic              deq;
   logic [ADDR_W-1:0] head_pc;
   logic [DATA_W-1:0] head_inst;

   // Bits of the stall bus that belong to later stages.
   logic              unused_stall;
   assign unused_stall = ^ctrl_stall[STALL_BUS-1:2];

   // The fetch-stall gate keeps a held PC from being captured twice; flush
   // outranks both sides so the redirect-cycle fetch is thrown away.
   assign enq = ce_i & ~ctrl_stall[STALL_PC] & ~flush & (count < CNT_FULL);
   assign deq = (count != '0) & ~ctrl_stall[STALL_ID] & ~flush;

   fetch_q_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (enq),
      .waddr (wr_ptr),
      .wpc   (pc_i),
      .winst (inst_i),
      .raddr (rd_ptr),
      .rpc   (head_pc),
      .rinst (head_inst)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // Simultaneous enq and deq leaves the occupancy unchanged.
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Head outputs read straight from registered state; an empty queue
   // presents an all-zero word, which decode treats as a NOP bubble.
   always_comb begin
      id_valid = (count != '0);
      id_pc    = '0;
      id_inst  = '0;
      if (id_valid) begin
         id_pc   = head_pc;
         id_inst = head_inst;
      end
   end

   // Depends only on count, so there is no input-to-output path here.
   assign stallreq_if = (count >= CNT_ALMOST);
   assign count_o     = count;

endmodule : inst_fetch_queue

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic [31:0] inst_i;
   logic [5:0]  ctrl_stall;
   logic        flush;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        stallreq_if;
   logic [2:0]  count_o;

   int n_pass  = 0;
   int n_total = 0;

   inst_fetch_queue #(
      .DEPTH  (4),
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc_i),
      .ce_i        (ce_i),
      .inst_i      (inst_i),
      .ctrl_stall  (ctrl_stall),
      .flush       (flush),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .id_valid    (id_valid),
      .stallreq_if (stallreq_if),
      .count_o     (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        ce;
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [2:0]  e_cnt;
      logic        e_sr;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   function automatic vec_t mk(input logic ce, input logic [5:0] st, input logic fl,
                               input logic [31:0] pc, input logic ev,
                               input logic [31:0] epc, input logic [2:0] ec,
                               input logic esr);
      vec_t v;
      v.ce = ce; v.stall = st; v.flush = fl; v.pc = pc;
      v.e_valid = ev; v.e_pc = epc; v.e_cnt = ec; v.e_sr = esr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [2:0] ec, input logic esr);
      logic [31:0] einst;
      einst = ev ? inst_of(epc) : 32'h0;
      check({tag, ".valid"},    {31'h0, id_valid},    {31'h0, ev});
      check({tag, ".pc"},       id_pc,                ev ? epc : 32'h0);
      check({tag, ".inst"},     id_inst,              einst);
      check({tag, ".count"},    {29'h0, count_o},     {29'h0, ec});
      check({tag, ".stallreq"}, {31'h0, stallreq_if}, {31'h0, esr});
   endtask

   task automatic drive(input logic ce, input logic [5:0] st, input logic fl,
                        input logic [31:0] pc);
      ce_i = ce; ctrl_stall = st; flush = fl; pc_i = pc; inst_i = inst_of(pc);
   endtask

   initial begin
      logic [31:0] mq [$];
      logic [31:0] pc_next;
      int          pushed;
      int          received;
      logic        s0;
      logic        s1;
      logic        fetch;

      //           ce  stall      fl pc          valid pc        cnt sr
      vecs[0]  = mk(1, 6'b000000, 0, 32'h00,      1, 32'h00,   3'd1, 0); // streaming
      vecs[1]  = mk(1, 6'b000000, 0, 32'h04,      1, 32'h04,   3'd1, 0);
      vecs[2]  = mk(1, 6'b000000, 0, 32'h08,      1, 32'h08,   3'd1, 0);
      vecs[3]  = mk(1, 6'b000010, 0, 32'h0C,      1, 32'h08,   3'd2, 0); // ID stall fill
      vecs[4]  = mk(1, 6'b000010, 0, 32'h10,      1, 32'h08,   3'd3, 1);
      vecs[5]  = mk(1, 6'b000011, 0, 32'h14,      1, 32'h08,   3'd3, 1); // PC held, no dup
      vecs[6]  = mk(1, 6'b000011, 0, 32'h14,      1, 32'h08,   3'd3, 1);
      vecs[7]  = mk(1, 6'b000010, 0, 32'h14,      1, 32'h08,   3'd4, 1); // reaches full
      vecs[8]  = mk(1, 6'b000010, 0, 32'h18,      1, 32'h08,   3'd4, 1); // enq at full refused
      vecs[9]  = mk(1, 6'b000001, 0, 32'h18,      1, 32'h0C,   3'd3, 1); // deq only
      vecs[10] = mk(1, 6'b000000, 0, 32'h18,      1, 32'h10,   3'd3, 1); // enq+deq
      vecs[11] = mk(1, 6'b000000, 0, 32'h1C,      1, 32'h14,   3'd3, 1);
      vecs[12] = mk(1, 6'b000000, 0, 32'h20,      1, 32'h18,   3'd3, 1);
      vecs[13] = mk(1, 6'b000000, 1, 32'h40,      0, 32'h00,   3'd0, 0); // flush
      vecs[14] = mk(1, 6'b000000, 0, 32'h100,     1, 32'h100,  3'd1, 0); // branch target
      vecs[15] = mk(0, 6'b000000, 0, 32'h104,     0, 32'h00,   3'd0, 0); // drain
      vecs[16] = mk(0, 6'b000010, 0, 32'h104,     0, 32'h00,   3'd0, 0); // ID stall, empty

      // Reset state
      rst = 1'b0;
      drive(0, 6'b0, 0, 32'h0);
      @(posedge clk); #1;
      check_all("reset", 0, 32'h0, 3'd0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all("idle", 0, 32'h0, 3'd0, 0);

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].ce, vecs[i].stall, vecs[i].flush, vecs[i].pc);
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                   vecs[i].e_cnt, vecs[i].e_sr);
      end

      // Wrap-around: 12 instructions, random ID stalls, stall controller
      // feeding stallreq_if back as the fetch stall.
      pc_next  = 32'h300;
      pushed   = 0;
      received = 0;
      for (int cyc = 0; cyc < 400 && received < 12; cyc++) begin
         s0    = stallreq_if;
         s1    = ($urandom_range(0, 2) == 0);
         fetch = (pushed < 12);
         drive(fetch, {4'b0, s1, s0}, 0, pc_next);
         check("wrap.count", {29'h0, count_o}, mq.size());
         if (mq.size() != 0 && !s1) begin
            check("wrap.pc",   id_pc,   mq[0]);
            check("wrap.inst", id_inst, inst_of(mq[0]));
            void'(mq.pop_front());
            received++;
         end
         if (fetch && !s0) begin
            mq.push_back(pc_next);
            pc_next += 32'h4;
            pushed++;
         end
         @(posedge clk); #1;
      end
      check("wrap.received", received, 12);

      // Async reset mid-stream with two entries queued
      drive(1, 6'b000010, 0, 32'h500);
      @(posedge clk); #1;
      drive(1, 6'b000010, 0, 32'h504);
      @(posedge clk); #1;
      drive(0, 6'b000010, 0, 32'h508);
      check_all("pre_areset", 1, 32'h500, 3'd2, 0);
      #2;
      rst = 1'b0;
      #1;
      check_all("areset", 0, 32'h0, 3'd0, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1, 6'b000000, 0, 32'h600);
      @(posedge clk); #1;
      check_all("resume", 1, 32'h600, 3'd1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_inst_fetch_queue
